// File: rtl/mips_mc_pkg.sv
// Shared constants for the multicycle MIPS sequencing controller:
// state encodings, opcodes, ALU-op codes, mux-select encodings, the
// control bundle and small helpers used by both the decoder and the top.
package mips_mc_pkg;

  // State encodings (also visible on the debug state port)
  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXEC    = 4'd6;
  localparam logic [3:0] S_ALUWB   = 4'd7;
  localparam logic [3:0] S_BRANCH  = 4'd8;
  localparam logic [3:0] S_JUMP    = 4'd9;
  localparam logic [3:0] S_ADDI_EX = 4'd10;
  localparam logic [3:0] S_ADDI_WB = 4'd11;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Codes passed to alu_control_unit
  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_RTYPE = 4'd15;

  // PC source select
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  // ALU B operand select
  localparam logic [1:0] SRC_B_RT      = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_IMM     = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

  // Every datapath control the sequencer drives, bundled so that the
  // reset gating in the top can clear them all in one place.
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       illegal;
  } ctrl_t;

  // True for the opcodes this controller knows how to sequence.
  function automatic logic opcode_known(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW: opcode_known = 1'b1;
      default:                                              opcode_known = 1'b0;
    endcase
  endfunction

  // Successor of DECODE for a given opcode; unknown opcodes restart at FETCH.
  function automatic logic [3:0] decode_target(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW:   decode_target = S_MEMADR;
      OP_RTYPE:       decode_target = S_EXEC;
      OP_BEQ, OP_BNE: decode_target = S_BRANCH;
      OP_J:           decode_target = S_JUMP;
      OP_ADDI:        decode_target = S_ADDI_EX;
      default:        decode_target = S_FETCH;
    endcase
  endfunction

  // An instruction retires on the edge that leaves its final state for FETCH.
  // A store only finishes once the memory accepts the write.
  function automatic logic retires(input logic [3:0] st, input logic ready);
    case (st)
      S_MEMWB, S_ALUWB, S_ADDI_WB, S_JUMP, S_BRANCH: retires = 1'b1;
      S_MEMWR:                                       retires = ready;
      default:                                       retires = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Purely combinational control decoder: maps the current state (plus the
// few Mealy qualifiers opcode, zero and mem_ready) onto the datapath
// controls. Everything not explicitly set for a state stays 0.
module multicycle_ctrl_decode
  import mips_mc_pkg::*;
(
  input  logic [3:0] state,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  // Per-state control table with Mealy terms for fetch completion,
  // branch resolution and illegal-opcode detection.
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.i_or_d    = 1'b0;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.alu_op    = ALU_ADD;
        if (mem_ready) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          ctrl.pc_src   = PC_SRC_ALU;
        end
      end
      S_DECODE: begin
        // ALU precomputes PC + (sext(imm) << 2) for a possible branch
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRC_B_IMM_SH2;
        ctrl.alu_op    = ALU_ADD;
        ctrl.illegal   = ~opcode_known(opcode);
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_req = 1'b1;
        ctrl.i_or_d  = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b0;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_req = 1'b1;
        ctrl.mem_we  = 1'b1;
        ctrl.i_or_d  = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_RT;
        ctrl.alu_op    = ALU_RTYPE;
      end
      S_ALUWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.mem_to_reg = 1'b0;
      end
      S_BRANCH: begin
        // Compare rs - rt; take the target held in ALUOut on the right flag
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_RT;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_src    = PC_SRC_ALUOUT;
        ctrl.pc_write  = ((opcode == OP_BEQ) &  zero) |
                         ((opcode == OP_BNE) & ~zero);
      end
      S_JUMP: begin
        ctrl.pc_src   = PC_SRC_JUMP;
        ctrl.pc_write = 1'b1;
      end
      S_ADDI_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_ADDI_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b0;
        ctrl.mem_to_reg = 1'b0;
      end
      default: begin
        // Unused encodings: flag it and let the top steer back to FETCH
        ctrl.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS sequencing controller. Holds the state register, the
// next-state logic and the retired-instruction counter; the control
// outputs come from multicycle_ctrl_decode and are cleared while rst is
// high so that nothing (including a memory request) leaks out of reset.
module multicycle_control
  import mips_mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_op,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  logic [3:0]       state_reg;
  logic [3:0]       state_next;
  logic [CNT_W-1:0] count_reg;
  ctrl_t            dec_ctrl;
  ctrl_t            out_ctrl;

  multicycle_ctrl_decode u_decode (
    .state     (state_reg),
    .opcode    (opcode),
    .zero      (zero),
    .mem_ready (mem_ready),
    .ctrl      (dec_ctrl)
  );

  // Next state: memory states wait on mem_ready, DECODE dispatches on opcode.
  always_comb begin
    state_next = S_FETCH;
    case (state_reg)
      S_FETCH:   state_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:  state_next = decode_target(opcode);
      S_MEMADR:  state_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_next = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:   state_next = S_FETCH;
      S_MEMWR:   state_next = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:    state_next = S_ALUWB;
      S_ALUWB:   state_next = S_FETCH;
      S_BRANCH:  state_next = S_FETCH;
      S_JUMP:    state_next = S_FETCH;
      S_ADDI_EX: state_next = S_ADDI_WB;
      S_ADDI_WB: state_next = S_FETCH;
      default:   state_next = S_FETCH;
    endcase
  end

  // State register and retire counter; reset wins over any completing access.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_reg <= S_FETCH;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (retires(state_reg, mem_ready)) begin
        count_reg <= count_reg + CNT_W'(1);
      end
    end
  end

  // Force every control low during reset so a pending access is dropped.
  always_comb begin
    out_ctrl = rst ? '0 : dec_ctrl;
  end

  assign mem_req     = out_ctrl.mem_req;
  assign mem_we      = out_ctrl.mem_we;
  assign i_or_d      = out_ctrl.i_or_d;
  assign ir_write    = out_ctrl.ir_write;
  assign pc_write    = out_ctrl.pc_write;
  assign pc_src      = out_ctrl.pc_src;
  assign alu_src_a   = out_ctrl.alu_src_a;
  assign alu_src_b   = out_ctrl.alu_src_b;
  assign alu_op      = out_ctrl.alu_op;
  assign reg_dst     = out_ctrl.reg_dst;
  assign mem_to_reg  = out_ctrl.mem_to_reg;
  assign reg_write   = out_ctrl.reg_write;
  assign illegal     = out_ctrl.illegal;
  assign state       = state_reg;
  assign instr_count = count_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control. Each cycle the expected state,
// control vector and instruction count are pushed to a scoreboard queue
// while inputs are driven, then popped and compared at the falling edge.
module tb_multicycle_control;

  logic        CLK = 1'b0;
  logic        rst;
  logic [5:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        mem_req, mem_we, i_or_d, ir_write, pc_write;
  logic [1:0]  pc_src;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [3:0]  alu_op;
  logic        reg_dst, mem_to_reg, reg_write, illegal;
  logic [3:0]  state;
  logic [31:0] instr_count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [3:0]  st;
    logic [17:0] cv;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  multicycle_control #(.CNT_W(32)) dut (
    .CLK         (CLK),
    .rst         (rst),
    .opcode      (opcode),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .i_or_d      (i_or_d),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_op      (alu_op),
    .reg_dst     (reg_dst),
    .mem_to_reg  (mem_to_reg),
    .reg_write   (reg_write),
    .illegal     (illegal),
    .state       (state),
    .instr_count (instr_count)
  );

  always #5 CLK = ~CLK;

  logic [17:0] obs_cv;
  assign obs_cv = {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src,
                   alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg,
                   reg_write, illegal};

  // Pack the expected controls by name, in the same order as obs_cv.
  function automatic logic [17:0] cv(
      input logic req, input logic we, input logic iod, input logic irw,
      input logic pcw, input logic [1:0] pcs, input logic sa,
      input logic [1:0] sb, input logic [3:0] op, input logic rd,
      input logic m2r, input logic rw, input logic ill);
    return {req, we, iod, irw, pcw, pcs, sa, sb, op, rd, m2r, rw, ill};
  endfunction

  logic [17:0] V_ZERO, V_FETCH_WAIT, V_FETCH_DONE, V_DEC, V_DEC_ILL;
  logic [17:0] V_MEMADR, V_MEMRD, V_MEMWB, V_MEMWR, V_EXEC, V_ALUWB;
  logic [17:0] V_BR_TAKEN, V_BR_NOT, V_JUMP, V_ADDI_EX, V_ADDI_WB;
  logic [31:0] cnt;

  // One clock: queue the expectation for the inputs already driven,
  // compare at the falling edge, then advance past the next rising edge.
  task automatic cyc(input string tag, input logic [3:0] st, input logic [17:0] v);
    exp_t e;
    exp_t g;
    e.tag = tag; e.st = st; e.cv = v; e.cnt = cnt;
    exp_q.push_back(e);
    @(negedge CLK);
    g = exp_q.pop_front();
    checks++;
    assert (state === g.st) else begin
      failures++;
      $error("FAIL %s.state observed=%0d expected=%0d", g.tag, state, g.st);
    end
    checks++;
    assert (obs_cv === g.cv) else begin
      failures++;
      $error("FAIL %s.ctrl observed=%b expected=%b", g.tag, obs_cv, g.cv);
    end
    checks++;
    assert (instr_count === g.cnt) else begin
      failures++;
      $error("FAIL %s.count observed=%0d expected=%0d", g.tag, instr_count, g.cnt);
    end
    $display("cycle %-10s state=%0d ctrl=%b count=%0d", g.tag, state, obs_cv, instr_count);
    @(posedge CLK);
    #1;
  endtask

  // Zero-wait fetch followed by decode of the given opcode.
  task automatic fetch_decode(input string tag, input logic [5:0] op);
    opcode = op; mem_ready = 1'b1;
    cyc({tag, "_F"}, 4'd0, V_FETCH_DONE);
    cyc({tag, "_D"}, 4'd1, V_DEC);
  endtask

  initial begin
    V_ZERO       = '0;
    V_FETCH_WAIT = cv(1,0,0,0,0,2'b00,0,2'b01,4'd0,0,0,0,0);
    V_FETCH_DONE = cv(1,0,0,1,1,2'b00,0,2'b01,4'd0,0,0,0,0);
    V_DEC        = cv(0,0,0,0,0,2'b00,0,2'b11,4'd0,0,0,0,0);
    V_DEC_ILL    = cv(0,0,0,0,0,2'b00,0,2'b11,4'd0,0,0,0,1);
    V_MEMADR     = cv(0,0,0,0,0,2'b00,1,2'b10,4'd0,0,0,0,0);
    V_MEMRD      = cv(1,0,1,0,0,2'b00,0,2'b00,4'd0,0,0,0,0);
    V_MEMWB      = cv(0,0,0,0,0,2'b00,0,2'b00,4'd0,0,1,1,0);
    V_MEMWR      = cv(1,1,1,0,0,2'b00,0,2'b00,4'd0,0,0,0,0);
    V_EXEC       = cv(0,0,0,0,0,2'b00,1,2'b00,4'd15,0,0,0,0);
    V_ALUWB      = cv(0,0,0,0,0,2'b00,0,2'b00,4'd0,1,0,1,0);
    V_BR_TAKEN   = cv(0,0,0,0,1,2'b01,1,2'b00,4'd1,0,0,0,0);
    V_BR_NOT     = cv(0,0,0,0,0,2'b01,1,2'b00,4'd1,0,0,0,0);
    V_JUMP       = cv(0,0,0,0,1,2'b10,0,2'b00,4'd0,0,0,0,0);
    V_ADDI_EX    = cv(0,0,0,0,0,2'b00,1,2'b10,4'd0,0,0,0,0);
    V_ADDI_WB    = cv(0,0,0,0,0,2'b00,0,2'b00,4'd0,0,0,1,0);
    cnt = 0;

    // Reset held 3 cycles with mem_ready high: all controls stay low
    rst = 1'b1; opcode = 6'h00; zero = 1'b0; mem_ready = 1'b1;
    @(posedge CLK); #1;
    cyc("rst0", 4'd0, V_ZERO);
    cyc("rst1", 4'd0, V_ZERO);
    cyc("rst2", 4'd0, V_ZERO);
    rst = 1'b0;

    // LW, zero-wait: 0,1,2,3,4 then back to FETCH with one retire
    fetch_decode("lw", 6'h23);
    cyc("lw_MA", 4'd2, V_MEMADR);
    cyc("lw_MR", 4'd3, V_MEMRD);
    cyc("lw_WB", 4'd4, V_MEMWB);
    cnt = 1;

    // SW with two wait cycles in MEMWR; the request is held steady
    fetch_decode("sw", 6'h2B);
    cyc("sw_MA", 4'd2, V_MEMADR);
    mem_ready = 1'b0;
    cyc("sw_W0", 4'd5, V_MEMWR);
    cyc("sw_W1", 4'd5, V_MEMWR);
    mem_ready = 1'b1;
    cyc("sw_W2", 4'd5, V_MEMWR);
    cnt = 2;

    // Fetch stalled one cycle, then R-type
    opcode = 6'h00; mem_ready = 1'b0;
    cyc("rt_Fw", 4'd0, V_FETCH_WAIT);
    fetch_decode("rt", 6'h00);
    cyc("rt_EX", 4'd6, V_EXEC);
    cyc("rt_WB", 4'd7, V_ALUWB);
    cnt = 3;

    // ADDI
    fetch_decode("addi", 6'h08);
    cyc("addi_EX", 4'd10, V_ADDI_EX);
    cyc("addi_WB", 4'd11, V_ADDI_WB);
    cnt = 4;

    // Branches against both zero values
    zero = 1'b1;
    fetch_decode("beq1", 6'h04);
    cyc("beq1_BR", 4'd8, V_BR_TAKEN);
    cnt = 5;
    fetch_decode("bne1", 6'h05);
    cyc("bne1_BR", 4'd8, V_BR_NOT);
    cnt = 6;
    zero = 1'b0;
    fetch_decode("beq0", 6'h04);
    cyc("beq0_BR", 4'd8, V_BR_NOT);
    cnt = 7;
    fetch_decode("bne0", 6'h05);
    cyc("bne0_BR", 4'd8, V_BR_TAKEN);
    cnt = 8;

    // Jump
    fetch_decode("j", 6'h02);
    cyc("j_JP", 4'd9, V_JUMP);
    cnt = 9;

    // Illegal opcode: one-cycle pulse in DECODE, no retire
    opcode = 6'h3F; mem_ready = 1'b1;
    cyc("ill_F", 4'd0, V_FETCH_DONE);
    cyc("ill_D", 4'd1, V_DEC_ILL);
    cyc("ill_after", 4'd0, V_FETCH_DONE);
    cyc("ill_D2", 4'd1, V_DEC_ILL);

    // Reset during MEMRD with mem_ready high: access dropped, count cleared
    fetch_decode("lwr", 6'h23);
    cyc("lwr_MA", 4'd2, V_MEMADR);
    rst = 1'b1;
    cyc("lwr_rst", 4'd3, V_ZERO);
    rst = 1'b0;
    cnt = 0;
    cyc("lwr_F", 4'd0, V_FETCH_DONE);
    cyc("lwr_D", 4'd1, V_DEC);

    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle sequencing controller for the 32-bit MIPS datapath. It replaces the single-cycle opcode decoder with a state machine that steps each instruction through fetch, decode, execute, memory and write-back. Instruction and data accesses share one memory port through a req/ready handshake. The block drives every datapath mux select, write enable and ALU-op code, and keeps a count of retired instructions.

## Interface
Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  6  IR[31:26]; stable from DECODE until the next fetch completes.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the requested access this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  write qualifier for mem_req.
- i_or_d  out  1  address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load the instruction register.
- pc_write  out  1  load the PC.
- pc_src  out  2  PC source: 00 = ALU result, 01 = ALUOut (branch target), 10 = jump target.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = rs.
- alu_src_b  out  2  ALU B select: 00 = rt, 01 = const 4, 10 = sext(imm), 11 = sext(imm)<<2.
- alu_op  out  4  to alu_control_unit: 0 = add, 1 = sub, 15 = R-type (decode funct).
- reg_dst  out  1  write-register select: 1 = rd, 0 = rt.
- mem_to_reg  out  1  register write-data select: 1 = MDR, 0 = ALUOut.
- reg_write  out  1  register file write enable.
- illegal  out  1  one-cycle pulse when an unknown opcode is decoded.
- state  out  4  current state, for debug.
- instr_count  out  CNT_W  retired-instruction counter.

## Operation
- Opcodes: RTYPE 0x00, J 0x02, BEQ 0x04, BNE 0x05, ADDI 0x08, LW 0x23, SW 0x2B.
- Any output not listed for a state is 0.
- FETCH (0): mem_req=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=0.
  - When mem_ready=1: ir_write=1, pc_write=1, pc_src=00, and go to DECODE.
  - Otherwise stay in FETCH.
- DECODE (1): alu_src_a=0, alu_src_b=11, alu_op=0 (precomputes the branch target). Next state by opcode:
  - LW/SW → MEMADR.
  - RTYPE → EXEC.
  - BEQ/BNE → BRANCH.
  - J → JUMP.
  - ADDI → ADDI_EX.
  - Anything else → FETCH, with illegal=1 for this cycle.
- MEMADR (2): alu_src_a=1, alu_src_b=10, alu_op=0. Go to MEMRD for LW, MEMWR for SW.
- MEMRD (3): mem_req=1, i_or_d=1. Go to MEMWB when mem_ready=1.
- MEMWB (4): reg_write=1, reg_dst=0, mem_to_reg=1. Go to FETCH.
- MEMWR (5): mem_req=1, mem_we=1, i_or_d=1. Go to FETCH when mem_ready=1.
- EXEC (6): alu_src_a=1, alu_src_b=00, alu_op=15. Go to ALUWB.
- ALUWB (7): reg_write=1, reg_dst=1, mem_to_reg=0. Go to FETCH.
- BRANCH (8): alu_src_a=1, alu_src_b=00, alu_op=1, pc_src=01. Go to FETCH.
  - pc_write = (BEQ & zero) | (BNE & ~zero).
- JUMP (9): pc_src=10, pc_write=1. Go to FETCH.
- ADDI_EX (10): alu_src_a=1, alu_src_b=10, alu_op=0. Go to ADDI_WB.
- ADDI_WB (11): reg_write=1, reg_dst=0, mem_to_reg=0. Go to FETCH.
- Encodings 12–15 are unreachable. If entered, go to FETCH with illegal=1.
- instr_count increments by 1, wrapping modulo 2^CNT_W, on every transition into FETCH from:
  - MEMWB, ALUWB, ADDI_WB, JUMP or BRANCH; or
  - MEMWR when the access completes.
- An illegal opcode does not increment instr_count.

## Timing
- Reset: when rst=1 at a rising edge, state becomes FETCH and instr_count becomes 0.
  - While rst=1, every control output is forced to 0, including mem_req.
  - The first mem_req appears in the first cycle after rst deasserts.
- rst has priority over mem_ready in the same cycle: no ir_write, pc_write or write enable is issued, and no count is taken.
- Reset mid-access abandons the access. The memory must treat a dropped mem_req as a cancel.
- Moore outputs decode from the state register. The following are Mealy:
  - ir_write and pc_write in FETCH (on mem_ready);
  - pc_write in BRANCH (on zero);
  - illegal in DECODE (on opcode).
- Handshake:
  - mem_req, mem_we and i_or_d are held constant until the cycle in which mem_ready=1.
  - The transfer completes in that cycle.
  - mem_ready is ignored when mem_req=0.
- CPI with zero-wait memory (mem_ready tied high): LW 5; SW, RTYPE and ADDI 4; BEQ, BNE and J 3.
- Each wait cycle on mem_ready adds 1 per memory access.

## Structure
- Package mips_mc_pkg holds the shared constants:
  - state encodings (S_FETCH…S_ADDI_WB);
  - opcode constants;
  - ALU-op codes (ALU_ADD=0, ALU_SUB=1, ALU_RTYPE=15);
  - pc_src and alu_src_b encodings.
- Sub-module multicycle_ctrl_decode is a purely combinational map from (state, opcode, zero, mem_ready) to the control outputs.
- The top level holds the state register, next-state logic and instr_count.

## Test plan
- Reset: hold rst for 3 cycles, then release with mem_ready=1 → all outputs 0 while rst is high; next cycle state=0 and mem_req=1.
- LW (0x23), mem_ready always high → state sequence 0,1,2,3,4,0; reg_write=1 with mem_to_reg=1 only in state 4; instr_count=1 after 5 cycles.
- SW (0x2B) with mem_ready low for 2 cycles in MEMWR → mem_req=1 and mem_we=1 held for 3 cycles; no reg_write; return to FETCH; instr_count=1.
- BEQ with zero=1 → pc_write=1 with pc_src=01 in state 8. BNE with zero=1 → pc_write=0.
- Opcode 0x3F → illegal pulses for 1 cycle in DECODE; next state 0; instr_count unchanged.
- rst asserted in MEMRD with mem_ready=1 in the same cycle → no reg_write; state=0; instr_count=0.
